// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory arbiter: widths, arbiter states and
// the encoding of which requester owns the previous cycle's read.
package imem_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        FETCH_PRI = 2'd0,
        HOST_PRI  = 2'd1,
        HOST_LOCK = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_HOST  = 1'b1
    } grantee_e;

endpackage

// File: rtl/imem_arbiter_starve_counter.sv
// Saturating count of denied host-request cycles. hit_o looks at the next
// value so the arbiter can switch priority on the same edge the limit is reached.
module starve_counter #(
    parameter int LIMIT = 8,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          hit_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = (cnt_d == CW'(LIMIT));

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between fetch (read-only) and the
// host loader. Fetch has priority; starvation and lock modes guarantee host progress.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int DATA_W     = IMEM_DATA_W,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic              f_gnt_o,
    output logic              f_rvalid_o,
    output logic [DATA_W-1:0] f_rdata_o,
    input  logic              h_req_i,
    input  logic              h_we_i,
    input  logic              h_lock_i,
    input  logic [ADDR_W-1:0] h_addr_i,
    input  logic [DATA_W-1:0] h_wdata_i,
    output logic              h_gnt_o,
    output logic              h_rvalid_o,
    output logic [DATA_W-1:0] h_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              f_stall_o
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    arb_state_e    state_q, state_d;
    grantee_e      grantee_q, grantee_d;
    logic          rd_vld_q, rd_vld_d;
    logic          starve_inc, starve_clr, starve_hit;
    logic [CW-1:0] starve_cnt;

    starve_counter #(
        .LIMIT (STARVE_LIM),
        .CW    (CW)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (starve_inc),
        .clr_i (starve_clr),
        .cnt_o (starve_cnt),
        .hit_o (starve_hit)
    );

    // Grants and counter control; kept apart from next-state so the counter's
    // look-ahead hit does not form a combinational loop through one process.
    always_comb begin
        f_gnt_o    = 1'b0;
        h_gnt_o    = 1'b0;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        unique case (state_q)
            FETCH_PRI: begin
                f_gnt_o    = f_req_i;
                h_gnt_o    = h_req_i & ~f_req_i;
                starve_inc = h_req_i & ~h_gnt_o;
                starve_clr = h_gnt_o;
            end
            HOST_PRI: begin
                h_gnt_o    = h_req_i;
                f_gnt_o    = f_req_i & ~h_req_i;
                starve_clr = 1'b1;
            end
            HOST_LOCK: begin
                h_gnt_o    = h_req_i;
                starve_clr = h_req_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_PRI: begin
                if (h_gnt_o && h_lock_i) begin
                    state_d = HOST_LOCK;
                end else if (starve_hit) begin
                    state_d = HOST_PRI;
                end
            end
            HOST_PRI:  state_d = (h_req_i && h_lock_i) ? HOST_LOCK : FETCH_PRI;
            HOST_LOCK: state_d = h_lock_i ? HOST_LOCK : FETCH_PRI;
            default:   state_d = FETCH_PRI;
        endcase
    end

    assign rd_vld_d  = f_gnt_o | (h_gnt_o & ~h_we_i);
    assign grantee_d = h_gnt_o ? GNT_HOST : GNT_FETCH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH_PRI;
            grantee_q <= GNT_FETCH;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grantee_q <= grantee_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    assign mem_addr_o  = h_gnt_o ? h_addr_i : f_addr_i;
    // Grants stay combinational in reset, so the write strobe is gated explicitly.
    assign mem_we_o    = h_gnt_o & h_we_i & rst_n;
    assign mem_wdata_o = h_wdata_i;

    assign f_rvalid_o  = rd_vld_q & (grantee_q == GNT_FETCH);
    assign h_rvalid_o  = rd_vld_q & (grantee_q == GNT_HOST);
    assign f_rdata_o   = mem_rdata_i;
    assign h_rdata_o   = mem_rdata_i;
    assign f_stall_o   = f_req_i & ~f_gnt_o;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: reset-time grant table, directed multi-cycle
// sequences and random traffic against a cycle-level priority model.
module tb_imem_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LIM = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          f_req = 1'b0, h_req = 1'b0, h_we = 1'b0, h_lock = 1'b0;
    logic [AW-1:0] f_addr = '0, h_addr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic          f_gnt, f_rvalid, h_gnt, h_rvalid, mem_we, f_stall;
    logic [DW-1:0] f_rdata, h_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;

    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt),
        .f_rvalid_o(f_rvalid), .f_rdata_o(f_rdata),
        .h_req_i(h_req), .h_we_i(h_we), .h_lock_i(h_lock), .h_addr_i(h_addr),
        .h_wdata_i(h_wdata), .h_gnt_o(h_gnt), .h_rvalid_o(h_rvalid), .h_rdata_o(h_rdata),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .f_stall_o(f_stall)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory the arbiter drives.
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: priority mode (0 fetch, 1 host once, 2 locked),
    // denied-streak length, expected memory image and pending read.
    int            mode, streak;
    logic [DW-1:0] refmem [1024];
    logic          pend_f, pend_h;
    logic [DW-1:0] pend_data;
    logic          obs_fgnt, obs_hgnt, obs_fstall, obs_frvalid, obs_hrvalid;
    logic [DW-1:0] obs_frdata, obs_hrdata;

    function automatic logic [DW-1:0] init_word(int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs already applied; check at negedge, model at posedge.
    task automatic step();
        logic ef, eh;
        @(negedge clk);
        case (mode)
            0:       begin ef = f_req;           eh = h_req && !f_req; end
            1:       begin ef = f_req && !h_req; eh = h_req;           end
            default: begin ef = 1'b0;            eh = h_req;           end
        endcase
        chk("f_gnt",    32'(f_gnt),    32'(ef));
        chk("h_gnt",    32'(h_gnt),    32'(eh));
        chk("f_stall",  32'(f_stall),  32'(f_req && !ef));
        chk("mem_we",   32'(mem_we),   32'(eh && h_we));
        chk("mem_addr", 32'(mem_addr), 32'(eh ? h_addr : f_addr));
        if (eh) chk("mem_wdata", mem_wdata, h_wdata);
        chk("f_rvalid", 32'(f_rvalid), 32'(pend_f));
        chk("h_rvalid", 32'(h_rvalid), 32'(pend_h));
        if (pend_f) chk("f_rdata", f_rdata, pend_data);
        if (pend_h) chk("h_rdata", h_rdata, pend_data);
        obs_fgnt = f_gnt;  obs_hgnt = h_gnt;  obs_fstall = f_stall;
        obs_frvalid = f_rvalid; obs_hrvalid = h_rvalid;
        obs_frdata = f_rdata;   obs_hrdata = h_rdata;
        @(posedge clk);
        pend_f    = ef;
        pend_h    = eh && !h_we;
        pend_data = refmem[eh ? h_addr : f_addr];
        if (eh && h_we) refmem[h_addr] = h_wdata;
        case (mode)
            0: begin
                if (eh) begin
                    streak = 0;
                    mode   = h_lock ? 2 : 0;
                end else if (h_req) begin
                    streak++;
                    if (streak >= LIM) mode = 1;
                end
            end
            1: begin
                streak = 0;
                mode   = (h_req && h_lock) ? 2 : 0;
            end
            default: begin
                if (eh) streak = 0;
                mode = h_lock ? 2 : 0;
            end
        endcase
        #1;
    endtask

    // Reset for one edge with inputs idle; returns just after an idle post-reset edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mode = 0; streak = 0; pend_f = 1'b0; pend_h = 1'b0;
        @(posedge clk);
        #1;
        chk("rst f_rvalid", 32'(f_rvalid), 32'd0);
        chk("rst h_rvalid", 32'(h_rvalid), 32'd0);
        chk("rst mem_we",   32'(mem_we),   32'd0);
        f_req = 1'b0; h_req = 1'b0; h_we = 1'b0; h_lock = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          fr, hr, hw, hl;
        logic [AW-1:0] fa, ha;
        logic          e_fgnt, e_hgnt, e_stall;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t vt [6];
    logic granted;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = init_word(i);
            refmem[i] = init_word(i);
        end
        mode = 0; streak = 0; pend_f = 1'b0; pend_h = 1'b0; pend_data = '0;

        // Grants during reset follow inputs with fetch priority; writes are blocked.
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd5, 10'd9, 1'b0, 1'b0, 1'b0, 10'd5};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd5, 10'd9, 1'b1, 1'b0, 1'b0, 10'd5};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 10'd5, 10'd9, 1'b0, 1'b1, 1'b0, 10'd9};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd7, 10'd9, 1'b1, 1'b0, 1'b0, 10'd7};
        vt[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 10'd3, 10'd8, 1'b0, 1'b1, 1'b0, 10'd8};
        vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd2, 10'd4, 1'b1, 1'b0, 1'b0, 10'd2};
        #2;
        for (int i = 0; i < 6; i++) begin
            f_req = vt[i].fr; h_req = vt[i].hr; h_we = vt[i].hw; h_lock = vt[i].hl;
            f_addr = vt[i].fa; h_addr = vt[i].ha;
            #1;
            chk("tbl f_gnt",    32'(f_gnt),    32'(vt[i].e_fgnt));
            chk("tbl h_gnt",    32'(h_gnt),    32'(vt[i].e_hgnt));
            chk("tbl f_stall",  32'(f_stall),  32'(vt[i].e_stall));
            chk("tbl mem_addr", 32'(mem_addr), 32'(vt[i].e_addr));
            chk("tbl mem_we",   32'(mem_we),   32'd0);
        end
        do_reset();

        // Fetch-only stream, reads return one cycle later.
        for (int k = 0; k < 3; k++) begin
            f_req = 1'b1; f_addr = AW'(k);
            step();
            chk("fetch gnt", 32'(obs_fgnt), 32'd1);
            if (k > 0) chk("fetch rdata", obs_frdata, init_word(k - 1));
        end
        f_req = 1'b0;
        step();
        chk("fetch last rvalid", 32'(obs_frvalid), 32'd1);
        chk("fetch last rdata",  obs_frdata, init_word(2));

        // Host write then read-back of the top address.
        h_req = 1'b1; h_we = 1'b1; h_addr = 10'h3FF; h_wdata = 32'hDEAD_BEEF;
        step();
        h_we = 1'b0;
        step();
        h_req = 1'b0;
        step();
        chk("host rd rvalid", 32'(obs_hrvalid), 32'd1);
        chk("host rd rdata",  obs_hrdata, 32'hDEAD_BEEF);

        // Starvation: host wins on the 9th cycle for exactly one cycle.
        do_reset();
        f_req = 1'b1; f_addr = 10'd20; h_req = 1'b1; h_we = 1'b0; h_addr = 10'd40;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("starve h_gnt",   32'(obs_hgnt),   32'(i == 8));
            chk("starve f_stall", 32'(obs_fstall), 32'(i == 8));
        end

        // Lock burst of 4 writes under continuous fetch.
        do_reset();
        f_req = 1'b1; f_addr = 10'd0;
        h_req = 1'b1; h_we = 1'b1; h_lock = 1'b1; h_addr = 10'h100; h_wdata = 32'hA000_0000;
        granted = 1'b0;
        for (int t = 0; t < 20 && !granted; t++) begin
            step();
            granted = obs_hgnt;
        end
        chk("lock first grant", 32'(granted), 32'd1);
        for (int k = 1; k < 4; k++) begin
            h_addr = AW'(10'h100 + k); h_wdata = 32'hA000_0000 + 32'(k);
            step();
            chk("lock h_gnt", 32'(obs_hgnt), 32'd1);
            chk("lock f_gnt", 32'(obs_fgnt), 32'd0);
        end
        h_req = 1'b0;
        step();
        chk("lock idle f_gnt", 32'(obs_fgnt), 32'd0);
        h_lock = 1'b0;
        step();
        chk("lock exit f_gnt", 32'(obs_fgnt), 32'd0);
        step();
        chk("lock resume f_gnt", 32'(obs_fgnt), 32'd1);
        for (int k = 0; k < 4; k++)
            chk("lock write landed", mem[256 + k], 32'hA000_0000 + 32'(k));

        // Host drops request while it holds priority; counter must restart.
        do_reset();
        f_req = 1'b1; f_addr = 10'd3; h_req = 1'b1; h_we = 1'b0; h_addr = 10'd7;
        repeat (LIM) step();
        h_req = 1'b0;
        step();
        chk("drop f_gnt", 32'(obs_fgnt), 32'd1);
        h_req = 1'b1;
        for (int i = 0; i <= LIM; i++) begin
            step();
            chk("drop restart h_gnt", 32'(obs_hgnt), 32'(i == LIM));
        end

        // Reset lands while a fetch read is in flight.
        f_req = 1'b1; h_req = 1'b0; f_addr = 10'd11;
        #1;
        chk("midrst f_gnt", 32'(f_gnt), 32'd1);
        do_reset();
        chk("midrst no rvalid", 32'(f_rvalid), 32'd0);
        step();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            f_req   = ($urandom_range(0, 9) < 7);
            h_req   = ($urandom_range(0, 9) < 5);
            h_we    = ($urandom_range(0, 9) < 4);
            h_lock  = ($urandom_range(0, 9) < 2);
            f_addr  = AW'($urandom_range(0, 15));
            h_addr  = AW'($urandom_range(0, 15));
            h_wdata = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbiter and sequencer for the single-port, 1024×32 synchronous-read instruction memory. It shares the port between two requesters: the pipeline fetch stage (reads only) and the host/debug loader (reads and writes, used for program download and readback). It sits between the fetch unit, the host interface and the memory. Fetch normally has priority; a starvation counter and a host lock mode guarantee loader progress.

## Interface
- ADDR_W, 10, word address width (1024 entries)
- DATA_W, 32, instruction width
- STARVE_LIM, 8, consecutive denied host-request cycles before host is forced to win (range 1..255)
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- f_req  in  1  fetch read request
- f_addr  in  ADDR_W  fetch word address
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_rvalid  out  1  fetch read data valid (registered)
- f_rdata  out  DATA_W  fetch read data; mirrors mem_rdata
- h_req  in  1  host request
- h_we  in  1  host write (1) / read (0)
- h_lock  in  1  host requests exclusive ownership for a burst
- h_addr  in  ADDR_W  host word address
- h_wdata  in  DATA_W  host write data
- h_gnt  out  1  host granted this cycle (combinational)
- h_rvalid  out  1  host read data valid (registered; reads only)
- h_rdata  out  DATA_W  host read data; mirrors mem_rdata
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the address is presented
- f_stall  out  1  f_req high and f_gnt low

## Operation
- State machine with states FETCH_PRI (reset), HOST_PRI, HOST_LOCK.
- FETCH_PRI: f_req wins. Host is granted only when f_req is low. Each cycle with h_req=1 and h_gnt=0 increments starve_cnt (saturating). If starve_cnt==STARVE_LIM, go to HOST_PRI.
- HOST_PRI: h_req wins for exactly one grant. On that grant, clear starve_cnt. Then go to HOST_LOCK if h_lock=1, else to FETCH_PRI. If h_req drops before it is granted, return to FETCH_PRI and clear starve_cnt.
- HOST_LOCK: only the host is granted, and f_gnt=0 even with the host idle. Exit to FETCH_PRI when h_lock=0, sampled on the clock edge. Enter from FETCH_PRI on any host grant with h_lock=1.
- At most one grant per cycle. The grantee's address drives mem_addr. With no grant, mem_addr=f_addr and mem_we=0.
- mem_we = h_gnt & h_we. mem_wdata = h_wdata whenever the host is granted.
- rvalid: the registered grantee flag of the previous cycle (read grants only) selects f_rvalid or h_rvalid.

## Timing
- Grant in cycle N, memory samples at the end of N, rvalid and rdata in N+1. Read latency is 1 cycle.
- Back-to-back grants are allowed every cycle; throughput is 1 access/cycle.
- A write in N followed by a host read of the same address in N+1 returns the new data in N+2.
- Worst-case host wait under continuous fetch: STARVE_LIM+1 cycles from h_req rising to h_gnt.
- Reset values: f_rvalid=0, h_rvalid=0, state=FETCH_PRI, starve_cnt=0, grantee flag=fetch. Grants follow inputs combinationally even in reset, but mem_we is forced 0 while rst_n=0.
- Reset asserted mid-access: the in-flight read is dropped and no rvalid is issued after reset release.
- Simultaneous f_req and h_req with h_lock in FETCH_PRI: fetch wins and the host counter increments.

## Structure
- Shared package `imem_pkg`: IMEM_ADDR_W, IMEM_DATA_W, state enum (FETCH_PRI, HOST_PRI, HOST_LOCK), grantee encoding.
- One sub-module, `starve_counter`: saturating counter with inc, clr and hit outputs, parameterised by limit.

## Test plan
- Fetch only: f_req every cycle, f_addr 0,1,2 → f_gnt=1 each cycle, f_rvalid=1 from cycle 1, f_rdata=mem[0],mem[1],mem[2].
- Host write then read: h_we=1, addr 0x3FF, data 0xDEADBEEF, then h_we=0 same address → h_rvalid one cycle after the read grant, h_rdata=0xDEADBEEF.
- Starvation: f_req and h_req held high, STARVE_LIM=8 → h_gnt in the 9th cycle for one cycle only, f_stall=1 that cycle, then fetch resumes.
- Lock burst: h_lock=1 with 4 host writes while f_req=1 → f_gnt=0 until the cycle after h_lock falls, and all 4 writes land.
- Reset mid-read: grant a fetch read, pull rst_n low before the next edge → f_rvalid=0, state FETCH_PRI, no spurious rvalid after release.
- Idle host drop: enter HOST_PRI, deassert h_req → return to FETCH_PRI with starve_cnt=0.
